// File: rtl/arb_grant_xfer_if.sv
// Grant, burst source and output-port bundle for arb_grant_xfer.
// err_timeout exists only when ARB_XFER_TIMEOUT_EN is defined.
interface arb_grant_xfer_if #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int LEN_W = 4
);
    logic [N-1:0]         grant;
    logic [N*DW-1:0]      req_data;
    logic [N*LEN_W-1:0]   req_len;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [$clog2(N)-1:0] out_owner;
    logic                 out_last;
    logic [N-1:0]         beat_ack;
    logic [N-1:0]         done;
    logic                 busy;
    logic                 err_multi;
`ifdef ARB_XFER_TIMEOUT_EN
    logic                 err_timeout;
`endif

    // Arbiter, sources and downstream sink as seen from outside the block.
    modport master (
        output grant, req_data, req_len, out_ready,
        input  out_valid, out_data, out_owner, out_last, beat_ack, done, busy, err_multi
`ifdef ARB_XFER_TIMEOUT_EN
        , input err_timeout
`endif
    );

    modport slave (
        input  grant, req_data, req_len, out_ready,
        output out_valid, out_data, out_owner, out_last, beat_ack, done, busy, err_multi
`ifdef ARB_XFER_TIMEOUT_EN
        , output err_timeout
`endif
    );
endinterface

// File: rtl/arb_grant_xfer.sv
// Locks onto the granted requester and forwards its multi-beat burst over a valid/ready port.
// Optional stall timeout: define ARB_XFER_TIMEOUT_EN.
module arb_grant_xfer #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int LEN_W  = 4,
    parameter int TO_CYC = 16
) (
    input logic          clk,
    input logic          rst,
    arb_grant_xfer_if.slave bus
);
    localparam int OW = $clog2(N);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] XFER    = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]       state;
    logic [OW-1:0]    owner;
    logic [LEN_W-1:0] cnt;
    logic             err_multi_q;
    logic [OW-1:0]    win_idx;
    logic [LEN_W-1:0] win_len;
    logic             multi_hot;
    logic             hs;
    logic [N-1:0]     owner_oh;

    // Lowest set grant bit wins, even when the grant is not one-hot.
    always_comb begin
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.grant[i]) win_idx = i[OW-1:0];
        end
    end

    assign win_len   = bus.req_len[win_idx*LEN_W +: LEN_W];
    assign multi_hot = |(bus.grant & (bus.grant - 1'b1));
    assign hs        = (state == XFER) && bus.out_ready;
    assign owner_oh  = {{(N-1){1'b0}}, 1'b1} << owner;

`ifdef ARB_XFER_TIMEOUT_EN
    localparam int SCW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    logic [SCW-1:0] sc;
    logic           err_to_q;
    logic           stall_expired;

    assign stall_expired = (state == XFER) && !bus.out_ready && (sc == SCW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sc       <= '0;
            err_to_q <= 1'b0;
        end else begin
            err_to_q <= stall_expired;
            if ((state == XFER) && !bus.out_ready && !stall_expired) sc <= sc + 1'b1;
            else                                                     sc <= '0;
        end
    end

    assign bus.err_timeout = err_to_q;
`else
    logic stall_expired;
    assign stall_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            cnt         <= '0;
            err_multi_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.grant) begin
                        owner <= win_idx;
                        cnt   <= win_len;
                        state <= XFER;
                        if (multi_hot) err_multi_q <= 1'b1;
                    end
                end
                XFER: begin
                    if (hs) begin
                        if (cnt != '0) cnt   <= cnt - 1'b1;
                        else           state <= DONE_ST;
                    end else if (stall_expired) begin
                        state <= DONE_ST;
                    end
                end
                DONE_ST: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data is steered straight from the owner's slice; sources hold it until beat_ack.
    assign bus.out_valid = (state == XFER);
    assign bus.out_data  = (state == XFER) ? bus.req_data[owner*DW +: DW] : '0;
    assign bus.out_owner = owner;
    assign bus.out_last  = (state == XFER) && (cnt == '0);
    assign bus.beat_ack  = hs ? owner_oh : '0;
    assign bus.done      = (state == DONE_ST) ? owner_oh : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.err_multi = err_multi_q;
endmodule

// File: tb/tb_arb_grant_xfer.sv
// Randomized directed-sequence bench for arb_grant_xfer with a transaction-level burst model.
module tb_arb_grant_xfer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    arb_grant_xfer_if #(.N(4), .DW(8), .LEN_W(4)) bus ();

    arb_grant_xfer #(.N(4), .DW(8), .LEN_W(4), .TO_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    logic exp_multi  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    function automatic int popcnt(input logic [3:0] g);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(g[i]);
        return c;
    endfunction

    // Starts in an IDLE cycle just after a rising edge; ends in the following IDLE cycle.
    // mode: 0 ready always high, 1 ready toggles 1,0,1,..., 2 random ready.
    task automatic burst(input logic [3:0] g, input logic [15:0] lens, input int mode,
                         input logic [3:0] busy_g);
        int          own, beats, rem, cyc, streak;
        logic        rdy, tog;
        logic [3:0]  oh;
        logic [7:0]  held;
        logic [31:0] d;
        own   = lowest(g);
        beats = int'(lens[own*4 +: 4]) + 1;
        oh    = 4'b0001 << own;
        if (popcnt(g) > 1) exp_multi = 1'b1;
        d            = $urandom;
        held         = d[own*8 +: 8];
        bus.grant    = g;
        bus.req_len  = lens;
        bus.req_data = d;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_valid", 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        bus.grant = busy_g;
        rem = beats; cyc = 0; streak = 0; tog = 1'b1;
        while (rem > 0 && cyc < 300) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = ~tog; end
                default: begin rdy = 1'($urandom); if (streak >= 8) rdy = 1'b1; end
            endcase
            d = $urandom;
            d[own*8 +: 8] = held;
            bus.req_data  = d;
            bus.out_ready = rdy;
            @(negedge clk);
            chk("xfer_valid", 32'(bus.out_valid), 1);
            chk("xfer_owner", 32'(bus.out_owner), 32'(own));
            chk("xfer_data", 32'(bus.out_data), 32'(held));
            chk("xfer_last", 32'(bus.out_last), 32'(rem == 1));
            chk("xfer_ack", 32'(bus.beat_ack), rdy ? 32'(oh) : 0);
            chk("xfer_busy", 32'(bus.busy), 1);
            chk("xfer_done", 32'(bus.done), 0);
            chk("err_multi", 32'(bus.err_multi), 32'(exp_multi));
            @(posedge clk); #1;
            if (rdy) begin rem--; held = 8'($urandom); streak = 0; end
            else streak++;
            cyc++;
        end
        if (rem > 0) chk("burst_bound", 32'(rem), 0);
        bus.out_ready = 1'($urandom);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'(oh));
        chk("done_valid", 32'(bus.out_valid), 0);
        chk("done_ack", 32'(bus.beat_ack), 0);
        chk("done_busy", 32'(bus.busy), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.grant = 4'b1111;
        bus.req_data = '0;
        bus.req_len = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_last", 32'(bus.out_last), 0);
        chk("rst_ack", 32'(bus.beat_ack), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_multi", 32'(bus.err_multi), 0);
        chk("rst_owner", 32'(bus.out_owner), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        @(posedge clk); #1;
        bus.grant = '0;
        rst = 1'b0;

        // Single beat, then 4-beat toggling-ready burst with a late grant that must wait.
        burst(4'b0010, 16'h0000, 0, 4'b0000);
        burst(4'b0100, 16'h0300, 1, 4'b1000);
        burst(4'b1000, 16'h2000, 0, 4'b0000);
        chk("multi_before", 32'(bus.err_multi), 0);
        burst(4'b1010, 16'h0050, 2, 4'b0000);
        chk("multi_sticky", 32'(bus.err_multi), 1);
        burst(4'b0001, 16'h000f, 0, 4'b0110);

        for (int k = 0; k < 25; k++) begin
            logic [3:0] g;
            g = 4'($urandom);
            if (g == 4'b0000) g = 4'b0100;
            burst(g, 16'($urandom), 2, 4'($urandom));
        end

        // Stall with ready held low.
        bus.grant = 4'b0001;
        bus.req_len = 16'h0000;
        bus.req_data = 32'h0000_005a;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.grant = '0;
`ifdef ARB_XFER_TIMEOUT_EN
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_to", 32'(bus.err_timeout), 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_pulse", 32'(bus.err_timeout), 1);
        chk("to_done", 32'(bus.done), 32'h1);
        chk("to_valid", 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_clear", 32'(bus.err_timeout), 0);
        chk("to_idle", 32'(bus.busy), 0);
        @(posedge clk); #1;
`else
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", 32'(bus.out_data), 32'h5a);
        chk("stall_busy", 32'(bus.busy), 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("stall_ack", 32'(bus.beat_ack), 32'h1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_done", 32'(bus.done), 32'h1);
        @(posedge clk); #1;
`endif

        // Reset mid-burst aborts without a done pulse and clears the sticky error.
        bus.grant = 4'b0100;
        bus.req_len = 16'h0500;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.grant = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(bus.out_valid), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_ack", 32'(bus.beat_ack), 0);
        chk("abort_multi", 32'(bus.err_multi), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_nodone", 32'(bus.done), 0);
        chk("abort_idle", 32'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
